// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, byte and status pulses out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] dout;
  logic       dout_rdy;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output dout,
    output dout_rdy,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  dout,
    input  dout_rdy,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled; flags false starts, framing errors
// and rides out held-low line breaks with a single error pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle, waiting for rx_s low
//   S_START | counting to mid start bit, then confirming or rejecting it
//   S_DATA  | sampling 8 data bits, one per OVERSAMPLE ticks
//   S_STOP  | sampling stop bit; high -> byte out, low -> frame error
//   S_BREAK | line stuck low after a framing error, waiting for it to rise
module uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    dout_q;
  logic          dout_rdy_q;
  logic          frame_err_q;

  logic          clr_cnt;
  logic          restart;
  logic          shift_en;
  logic          load_dout;
  logic          set_ferr;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    restart   = 1'b0;
    shift_en  = 1'b0;
    load_dout = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          clr_cnt   = 1'b1;
        end
      end
      S_START: begin
        if (tick && tick_cnt == HALF_LAST) begin
          restart   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && tick_cnt == FULL_LAST) begin
          restart  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick && tick_cnt == FULL_LAST) begin
          if (rx_s) begin
            load_dout = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            set_ferr  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters are re-phased at start detection so every sample lands mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      dout_q      <= '0;
      dout_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;

      if (clr_cnt || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (clr_cnt || restart) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (clr_cnt) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end

      if (shift_en) begin
        shift[bit_idx] <= rx_s;
      end

      if (load_dout) begin
        dout_q <= shift;
      end
      dout_rdy_q  <= load_dout;
      frame_err_q <= set_ferr;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_rdy  = dout_rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != S_IDLE);

endmodule
